// File: rtl/bitorder_param.sv
// Lane bit-order converter: collects DW-bit lanes of a byte (LSB lane first),
// then re-emits the completed byte one lane per cycle, MSB lane first
// (MODE=1) or in arrival order (MODE=0). Also flags frames that end
// mid-byte and counts completed bytes per frame.
module bitorder_param #(
    parameter int unsigned DW        = 2,
    parameter int unsigned BYTE_BITS = 8,
    parameter bit          MODE      = 1'b1,
    parameter int unsigned CNT_W     = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [DW-1:0]    axiid,
    output logic             axiov,
    output logic [DW-1:0]    axiod,
    output logic             partial_drop,
    output logic [CNT_W-1:0] byte_count
);

    localparam int unsigned      N       = BYTE_BITS / DW;
    localparam int unsigned      CW      = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]    LAST    = CW'(N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CW-1:0]        cnt_in;
    logic [BYTE_BITS-1:0] cap_buf;
    logic [BYTE_BITS-1:0] out_buf;
    logic [CW-1:0]        out_idx;
    logic                 out_act;
    logic                 prev_v;

    logic                 frame_start;
    logic                 byte_done;
    logic [CW-1:0]        lane_idx;
    logic [BYTE_BITS-1:0] cap_next;

    // Output lane i of a byte, in the configured order.
    function automatic logic [DW-1:0] pick(input logic [BYTE_BITS-1:0] b,
                                           input logic [CW-1:0] i);
        int unsigned pos;
        pos = MODE ? (N - 1 - 32'(i)) : 32'(i);
        return b[DW*pos +: DW];
    endfunction

    // Capture-side decode: lane position and the byte including this lane.
    always_comb begin
        frame_start = axiiv & ~prev_v;
        // A frame always begins at lane 0, whatever the counter holds.
        lane_idx    = frame_start ? '0 : cnt_in;
        byte_done   = axiiv & (lane_idx == LAST);
        cap_next    = cap_buf;
        cap_next[DW*lane_idx +: DW] = axiid;
    end

    // Input side: lane counter, capture buffer, frame tracking, drop pulse, byte count.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_in       <= '0;
            cap_buf      <= '0;
            prev_v       <= 1'b0;
            partial_drop <= 1'b0;
            byte_count   <= '0;
        end else begin
            prev_v       <= axiiv;
            // Only a frame that stopped with lanes pending raises the pulse.
            partial_drop <= ~axiiv & prev_v & (cnt_in != '0);
            if (axiiv) begin
                cap_buf <= cap_next;
                cnt_in  <= byte_done ? '0 : lane_idx + CW'(1);
            end else begin
                cnt_in  <= '0;
            end
            if (frame_start) begin
                byte_count <= byte_done ? CNT_W'(1) : '0;
            end else if (byte_done && byte_count != CNT_MAX) begin
                byte_count <= byte_count + CNT_W'(1);
            end
        end
    end

    // Output side: a completed byte preempts nothing, since the previous
    // byte's last lane leaves on the same edge the new byte loads.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_buf <= '0;
            out_idx <= '0;
            out_act <= 1'b0;
            axiov   <= 1'b0;
            axiod   <= '0;
        end else if (byte_done) begin
            out_buf <= cap_next;
            out_idx <= CW'(1);
            out_act <= (N > 1);
            axiov   <= 1'b1;
            axiod   <= pick(cap_next, '0);
        end else if (out_act) begin
            out_idx <= out_idx + CW'(1);
            out_act <= (out_idx != LAST);
            axiov   <= 1'b1;
            axiod   <= pick(out_buf, out_idx);
        end else begin
            axiov   <= 1'b0;
            axiod   <= '0;
        end
    end

endmodule

// File: tb/tb_bitorder_param.sv
// Directed bench for bitorder_param: default (DW=2, MODE=1), MODE=0 and DW=4 instances.
module tb_bitorder_param;

    logic        clk = 1'b0;
    logic        rst;
    logic        v;
    logic [1:0]  d;
    logic        v4;
    logic [3:0]  d4;

    logic        ov1, ov0, ov4;
    logic [1:0]  od1, od0;
    logic [3:0]  od4;
    logic        pd1, pd0, pd4;
    logic [11:0] bc1, bc0, bc4;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    bitorder_param #(.DW(2), .BYTE_BITS(8), .MODE(1'b1), .CNT_W(12)) u_m1 (
        .clk(clk), .rst(rst), .axiiv(v), .axiid(d),
        .axiov(ov1), .axiod(od1), .partial_drop(pd1), .byte_count(bc1));

    bitorder_param #(.DW(2), .BYTE_BITS(8), .MODE(1'b0), .CNT_W(12)) u_m0 (
        .clk(clk), .rst(rst), .axiiv(v), .axiid(d),
        .axiov(ov0), .axiod(od0), .partial_drop(pd0), .byte_count(bc0));

    bitorder_param #(.DW(4), .BYTE_BITS(8), .MODE(1'b1), .CNT_W(12)) u_dw4 (
        .clk(clk), .rst(rst), .axiiv(v4), .axiid(d4),
        .axiov(ov4), .axiod(od4), .partial_drop(pd4), .byte_count(bc4));

    typedef struct {
        logic        v;
        logic [1:0]  d;
        logic        ov;
        logic [1:0]  od1;
        logic [1:0]  od0;
        logic        pd;
        logic [11:0] bc;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [1:0] id, input logic eov,
                                input logic [1:0] eod1, input logic [1:0] eod0,
                                input logic epd, input logic [11:0] ebc);
        vec_t r;
        r.v = iv; r.d = id; r.ov = eov; r.od1 = eod1; r.od0 = eod0; r.pd = epd; r.bc = ebc;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    initial begin
        logic [7:0] by;
        logic [1:0] last_lanes [4];
        int bad_ov, bad_od, pd_seen, first_ov, n_ov;

        // AA, BB, CC back to back (MODE=1 / MODE=0 outputs)
        vq.push_back(mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b10, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b10, 1, 2'b10, 2'b10, 0, 1));
        vq.push_back(mk(1, 2'b11, 1, 2'b10, 2'b10, 0, 1));
        vq.push_back(mk(1, 2'b10, 1, 2'b10, 2'b10, 0, 1));
        vq.push_back(mk(1, 2'b11, 1, 2'b10, 2'b10, 0, 1));
        vq.push_back(mk(1, 2'b10, 1, 2'b10, 2'b11, 0, 2));
        vq.push_back(mk(1, 2'b00, 1, 2'b11, 2'b10, 0, 2));
        vq.push_back(mk(1, 2'b11, 1, 2'b10, 2'b11, 0, 2));
        vq.push_back(mk(1, 2'b00, 1, 2'b11, 2'b10, 0, 2));
        vq.push_back(mk(1, 2'b11, 1, 2'b11, 2'b00, 0, 3));
        vq.push_back(mk(0, 2'b00, 1, 2'b00, 2'b11, 0, 3));
        vq.push_back(mk(0, 2'b00, 1, 2'b11, 2'b00, 0, 3));
        vq.push_back(mk(0, 2'b00, 1, 2'b00, 2'b11, 0, 3));
        vq.push_back(mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 3));
        // 0xFF then two lanes, then the frame ends mid-byte
        vq.push_back(mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b11, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b11, 1, 2'b11, 2'b11, 0, 1));
        vq.push_back(mk(1, 2'b01, 1, 2'b11, 2'b11, 0, 1));
        vq.push_back(mk(1, 2'b10, 1, 2'b11, 2'b11, 0, 1));
        vq.push_back(mk(0, 2'b11, 1, 2'b11, 2'b11, 1, 1));
        vq.push_back(mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 1));
        vq.push_back(mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 1));
        // following clean frame: single 0xD5
        vq.push_back(mk(1, 2'b01, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b01, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b01, 0, 2'b00, 2'b00, 0, 0));
        vq.push_back(mk(1, 2'b11, 1, 2'b11, 2'b01, 0, 1));
        vq.push_back(mk(0, 2'b00, 1, 2'b01, 2'b01, 0, 1));
        vq.push_back(mk(0, 2'b00, 1, 2'b01, 2'b01, 0, 1));
        vq.push_back(mk(0, 2'b00, 1, 2'b01, 2'b11, 0, 1));
        vq.push_back(mk(0, 2'b00, 0, 2'b00, 2'b00, 0, 1));

        // Reset state
        rst = 1'b0; v = 1'b0; d = 2'b00; v4 = 1'b0; d4 = 4'h0;
        tick();
        tick();
        chk("reset_m1", {ov1, od1, pd1, bc1}, 0);
        chk("reset_m0", {ov0, od0, pd0, bc0}, 0);
        chk("reset_dw4", {ov4, od4, pd4, bc4}, 0);
        rst = 1'b1;
        tick();

        // Table vectors
        for (int i = 0; i < vq.size(); i++) begin
            v = vq[i].v;
            d = vq[i].d;
            tick();
            chk($sformatf("row%0d", i), {ov1, od1, od0, pd1, bc1},
                {vq[i].ov, vq[i].od1, vq[i].od0, vq[i].pd, vq[i].bc});
        end
        chk("row_mode0_valid_match", {ov0, pd0, bc0}, {1'b0, 1'b0, 12'd1});

        // Preamble: 0x55 x7 then 0xD5, continuous
        bad_ov = 0; bad_od = 0; pd_seen = 0; first_ov = -1; n_ov = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 32) begin
                by = (c / 4 < 7) ? 8'h55 : 8'hD5;
                v = 1'b1;
                d = by[2*(c%4) +: 2];
            end else begin
                v = 1'b0;
                d = 2'b00;
            end
            tick();
            if (ov1 !== ((c >= 3) && (c < 35))) bad_ov++;
            if (ov1 === 1'b1) begin
                if (first_ov < 0) first_ov = c;
                n_ov++;
            end
            if ((c >= 3) && (c < 35)) begin
                by = ((c - 3) / 4 < 7) ? 8'h55 : 8'hD5;
                if (od1 !== by[7-2*((c-3)%4) -: 2]) bad_od++;
                if (c >= 31) last_lanes[c-31] = od1;
            end else if (od1 !== 2'b00) begin
                bad_od++;
            end
            if (pd1 !== 1'b0) pd_seen++;
        end
        chk("pre_first_out_cycle", first_ov, 3);
        chk("pre_valid_count", n_ov, 32);
        chk("pre_valid_pattern", bad_ov, 0);
        chk("pre_data_pattern", bad_od, 0);
        chk("pre_last_byte", {last_lanes[0], last_lanes[1], last_lanes[2], last_lanes[3]},
            8'b11_01_01_01);
        chk("pre_byte_count", bc1, 8);
        chk("pre_no_partial", pd_seen, 0);

        // Reset during the 2nd output lane of 0xAA
        for (int k = 0; k < 4; k++) begin
            v = 1'b1;
            d = 2'b10;
            tick();
        end
        chk("rst_first_lane", {ov1, od1, bc1}, {1'b1, 2'b10, 12'd1});
        v = 1'b0;
        rst = 1'b0;
        tick();
        chk("rst_outputs_cleared", {ov1, od1, pd1, bc1}, 0);
        rst = 1'b1;
        bad_ov = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if ({ov1, od1, pd1} !== 4'b0) bad_ov++;
        end
        chk("rst_no_resume", bad_ov, 0);
        chk("rst_byte_count", bc1, 0);

        // DW=4: 0x3C sent as C,3 then a 1-lane frame
        v4 = 1'b1; d4 = 4'hC;
        tick();
        chk("dw4_lat_idle", ov4, 0);
        d4 = 4'h3;
        tick();
        chk("dw4_out0", {ov4, od4}, {1'b1, 4'h3});
        v4 = 1'b0; d4 = 4'h0;
        tick();
        chk("dw4_out1", {ov4, od4}, {1'b1, 4'hC});
        tick();
        chk("dw4_done", {ov4, od4, pd4, bc4}, {1'b0, 4'h0, 1'b0, 12'd1});
        v4 = 1'b1; d4 = 4'h5;
        tick();
        chk("dw4_short_start", {ov4, pd4, bc4}, {1'b0, 1'b0, 12'd0});
        v4 = 1'b0; d4 = 4'h0;
        tick();
        chk("dw4_short_drop", {ov4, pd4}, {1'b0, 1'b1});
        tick();
        chk("dw4_drop_once", {ov4, od4, pd4, bc4}, {1'b0, 4'h0, 1'b0, 12'd0});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
